eight_bit_adder_core: RTL and testbench
=======================================

# eight_bit_adder_core

Registered 8-bit binary adder with carry-in and carry-out. Computes a + b + cin over two 8-bit operands and a 1-bit carry, and presents the 8-bit sum and carry-out from output registers one clock after the operands are sampled. It serves as the basic arithmetic datapath cell: it can be chained through cin/cout for wider words, or used standalone in ALU and accumulator paths.

## Interface

Parameters
- None; width is fixed at 8 bits.

Ports
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all output registers immediately.
- a  input  8  operand A, unsigned.
- b  input  8  operand B, unsigned.
- cin  input  1  carry-in, weight 1.
- sum  output  8  registered result bits [7:0] of a + b + cin.
- cout  output  1  registered carry-out, bit 8 of a + b + cin.

## Operation

- The combinational core is a ripple-carry chain of eight full-adder cells, bit 0 to bit 7.
- Each full-adder cell is built from two half adders plus an OR gate:
  - s_i = a_i ^ b_i ^ c_i
  - c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i))
- c_0 = cin; cout_next = c_8.
- Arithmetic is unsigned with a 9-bit result: {cout, sum} = a + b + cin. Range is 0..511.
- No overflow flag and no saturation; the result wraps modulo 256 in sum, with the excess reported in cout.
- Output register:
  - On each rising clk edge with rst low: sum <= s[7:0] and cout <= c_8.
  - Registers load every cycle; there is no enable and no handshake.
- Inputs are assumed stable around the clock edge. There are no input registers.
- Chaining: the cout of the lower slice drives the cin of the upper slice. Each slice adds its own cycle of latency; the block does not compensate for this.

## Timing

- Reset: while rst = 1, sum = 8'd0 and cout = 1'b0, asynchronously and independent of clk.
- Reset release: the first rising clk edge after rst deasserts loads the result of the current inputs.
- Latency: exactly 1 cycle. Inputs present before rising edge N appear on sum/cout after edge N.
- Throughput: one new addition per cycle.
- Reset mid-operation:
  - Asserting rst clears the outputs at once, discarding any in-flight result.
  - Inputs applied during reset are not retained.
- Simultaneous changes of a, b and cin in one cycle form a single operation; there is no ordering between them.
- Critical path: a[0]/b[0]/cin through eight carry stages to the cout register. It must meet timing at the system clock.

## Test plan

- Reset: assert rst with a = 255, b = 255, cin = 1 -> sum = 0, cout = 0 immediately, with no clock edge.
- Zero: a = 0, b = 0, cin = 0, one edge -> sum = 0, cout = 0.
- Full overflow: a = 255, b = 255, cin = 0 -> sum = 254, cout = 1 after one edge; then cin = 1 -> sum = 255, cout = 1 on the next edge.
- Mixed carry-in: a = 128, b = 32, cin = 1 -> sum = 161, cout = 0.
- Carry ripple through all bits: a = 255, b = 0, cin = 1 -> sum = 0, cout = 1.
- Back-to-back operations plus mid-stream reset:
  - Apply the four vectors above on consecutive edges; each result appears exactly one cycle later.
  - Pulse rst between edges; outputs go to 0 asynchronously, and the next edge after release shows the current inputs' sum.

Source files
------------

// File: rtl/eight_bit_adder_core.sv
// Registered 8-bit ripple-carry adder: {cout, sum} = a + b + cin, one cycle after sampling.
// Each full-adder cell is two half adders joined by an OR of their carries.

module HalfAdder (
   input  logic x_i,
   input  logic y_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = x_i ^ y_i;
   assign c_o = x_i & y_i;

endmodule

module FullAdder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic halfSum;
   logic halfCarry0;
   logic halfCarry1;

   HalfAdder u_ha0 (
      .x_i (a_i),
      .y_i (b_i),
      .s_o (halfSum),
      .c_o (halfCarry0)
   );

   HalfAdder u_ha1 (
      .x_i (halfSum),
      .y_i (c_i),
      .s_o (s_o),
      .c_o (halfCarry1)
   );

   assign c_o = halfCarry0 | halfCarry1;

endmodule

module eight_bit_adder_core (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [8:0] carry;
   logic [7:0] sum_d;
   logic       cout_d;
   logic [7:0] sum_q;
   logic       cout_q;

   assign carry[0] = cin;

   // Carry ripples from bit 0 up to bit 7; carry[8] is the word's carry-out.
   for (genvar i = 0; i < 8; i++) begin : g_bit
      FullAdder u_fa (
         .a_i (a[i]),
         .b_i (b[i]),
         .c_i (carry[i]),
         .s_o (sum_d[i]),
         .c_o (carry[i+1])
      );
   end

   assign cout_d = carry[8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= 8'd0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_eight_bit_adder_core.sv
// Self-checking bench for eight_bit_adder_core: directed corner cases, back-to-back
// operation, asynchronous reset pulses and randomized vectors against an arithmetic model.

module tb_eight_bit_adder_core;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic [7:0] sum;
   logic       cout;

   int assertCount;
   int failCount;

   eight_bit_adder_core dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] refAdd(input logic [7:0] x, input logic [7:0] y, input logic c);
      int total;
      total = int'(x) + int'(y) + int'(c);
      return total[8:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got cout=%0b sum=%0d, expected cout=%0b sum=%0d",
                  tag, observed[8], observed[7:0], expected[8], expected[7:0]);
      end
   endtask

   // Drive one operand set, let one rising edge capture it, then sample 1 ns later.
   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic c);
      a   = x;
      b   = y;
      cin = c;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] vecA [4];
   logic [7:0] vecB [4];
   logic       vecC [4];

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst = 1'b0;
      a   = 8'd0;
      b   = 8'd0;
      cin = 1'b0;

      // Load a nonzero result, then reset asynchronously between edges.
      applyStimulus(8'd255, 8'd255, 1'b1);
      checkOutput("preload_511", {cout, sum}, 9'd511);
      rst = 1'b1;
      #1;
      checkOutput("async_reset", {cout, sum}, 9'd0);
      @(posedge clk);
      #1;
      checkOutput("reset_held_over_edge", {cout, sum}, 9'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(8'd0, 8'd0, 1'b0);
      checkOutput("zero", {cout, sum}, 9'd0);
      applyStimulus(8'd255, 8'd255, 1'b0);
      checkOutput("overflow_cin0", {cout, sum}, {1'b1, 8'd254});
      applyStimulus(8'd255, 8'd255, 1'b1);
      checkOutput("overflow_cin1", {cout, sum}, {1'b1, 8'd255});
      applyStimulus(8'd128, 8'd32, 1'b1);
      checkOutput("mixed_cin", {cout, sum}, {1'b0, 8'd161});
      applyStimulus(8'd255, 8'd0, 1'b1);
      checkOutput("full_ripple", {cout, sum}, {1'b1, 8'd0});

      // Back-to-back: each vector's result is visible exactly one edge later.
      vecA = '{8'd0, 8'd255, 8'd128, 8'd255};
      vecB = '{8'd0, 8'd255, 8'd32, 8'd0};
      vecC = '{1'b0, 1'b0, 1'b1, 1'b1};
      a = vecA[0]; b = vecB[0]; cin = vecC[0];
      for (int i = 0; i < 4; i++) begin
         a = vecA[i]; b = vecB[i]; cin = vecC[i];
         @(negedge clk);
         checkOutput($sformatf("b2b_before_edge_%0d", i), {cout, sum},
                     (i == 0) ? refAdd(8'd255, 8'd0, 1'b1) : refAdd(vecA[i-1], vecB[i-1], vecC[i-1]));
         @(posedge clk);
         #1;
         checkOutput($sformatf("b2b_after_edge_%0d", i), {cout, sum}, refAdd(vecA[i], vecB[i], vecC[i]));
      end

      // Mid-stream reset pulse; inputs applied during reset must not be retained.
      rst = 1'b1;
      a = 8'd200; b = 8'd100; cin = 1'b1;
      #1;
      checkOutput("midstream_reset", {cout, sum}, 9'd0);
      a = 8'd17; b = 8'd42; cin = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      checkOutput("reset_release_no_edge", {cout, sum}, 9'd0);
      @(posedge clk);
      #1;
      checkOutput("first_edge_after_release", {cout, sum}, refAdd(8'd17, 8'd42, 1'b0));

      // Randomized vectors with occasional asynchronous reset pulses.
      for (int i = 0; i < 300; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         logic       rc;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         applyStimulus(ra, rb, rc);
         checkOutput($sformatf("rand_%0d", i), {cout, sum}, refAdd(ra, rb, rc));
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            #1;
            checkOutput($sformatf("rand_reset_%0d", i), {cout, sum}, 9'd0);
            rst = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
